// File: rtl/if_id_reg_pkg.sv
// ---------------------------------------------------------------------------
// if_id_reg_pkg -- shared CPU constants for the IF/ID pipeline boundary.
//
// Contents:
//   CPU_NOP_INSTR   bubble encoding (ADD $0,$0,$0) used on flush/reset/halt
//   CPU_HLT_OPCODE  opcode field value (instr[15:12]) that identifies HLT
//   CPU_PC_RESET    value the PC fields take while reset is asserted
//   if_id_state_e   2-bit front-end halt FSM encoding
//   is_hlt()        decode helper: valid HLT sitting in a pipeline slot
// ---------------------------------------------------------------------------
package if_id_reg_pkg;

  localparam logic [15:0] CPU_NOP_INSTR  = 16'h0000;
  localparam logic [3:0]  CPU_HLT_OPCODE = 4'hF;
  localparam logic [15:0] CPU_PC_RESET   = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_HALT_PEND = 2'b01,
    ST_HALTED    = 2'b10
  } if_id_state_e;

  // A slot holds a HLT only if it is a real (non-bubble) instruction whose
  // opcode field matches; bubbles can never trigger a halt.
  function automatic logic is_hlt(
    input logic        valid,
    input logic [15:0] instr,
    input logic [3:0]  hlt_opcode
  );
    return valid && (instr[15:12] == hlt_opcode);
  endfunction

endpackage : if_id_reg_pkg

// File: rtl/if_id_reg_pipe_reg16.sv
// ---------------------------------------------------------------------------
// pipe_reg16 -- 16-bit pipeline register with write-enable and an
// asynchronous active-high reset to a caller-supplied value.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset; q takes rst_val immediately
//   en       write-enable; q holds when low
//   rst_val  value loaded while rst is high (tie to a constant)
//   d        data to capture
//   q        registered data
// ---------------------------------------------------------------------------
module pipe_reg16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] rst_val,
  input  logic [15:0] d,
  output logic [15:0] q
);

  // Storage: async reset to rst_val, otherwise capture d when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= rst_val;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : pipe_reg16

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg -- IF/ID pipeline register with stall, flush and HLT handling.
//
// Parameters:
//   NOP_INSTR   bubble encoding inserted on flush, reset and halt
//   HLT_OPCODE  instr[15:12] value recognised as HLT
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   if_instr        instruction from fetch
//   if_pc           PC of if_instr
//   if_pc_plus_two  if_pc + 2 from the fetch adder
//   stall           hold register contents (load-use hazard)
//   flush           squash the held instruction (branch taken in ID)
//   id_instr        registered instruction to decode
//   id_pc           registered PC
//   id_pc_plus_two  registered PC + 2
//   id_valid        id_instr is a real, non-squashed instruction
//   id_hlt          a valid HLT is currently held in ID
//   halted          sticky: front end frozen after HLT
//   fetch_hold      tells fetch to stop advancing the PC
//
// Update priority per edge: flush > stall > normal load. Once a HLT has been
// seen in ID with no stall/flush, the FSM spends one cycle in HALT_PEND
// (where a late flush can still cancel it as wrong-path) before freezing in
// HALTED until reset.
// ---------------------------------------------------------------------------
module if_id_reg
  import if_id_reg_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR  = CPU_NOP_INSTR,
  parameter logic [3:0]  HLT_OPCODE = CPU_HLT_OPCODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] if_instr,
  input  logic [15:0] if_pc,
  input  logic [15:0] if_pc_plus_two,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc,
  output logic [15:0] id_pc_plus_two,
  output logic        id_valid,
  output logic        id_hlt,
  output logic        halted,
  output logic        fetch_hold
);

  if_id_state_e state_r;
  if_id_state_e next_state_s;

  logic        valid_r;
  logic        valid_d_s;
  logic        instr_en_s;
  logic [15:0] instr_d_s;
  logic        pc_en_s;
  logic        id_hlt_s;
  logic        halted_s;
  logic        halt_pend_s;

  // Status decoded from registered state only.
  assign id_hlt_s    = is_hlt(valid_r, id_instr, HLT_OPCODE);
  assign halted_s    = (state_r == ST_HALTED);
  assign halt_pend_s = (state_r == ST_HALT_PEND);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic. A stalled HLT stays in RUN; only an unstalled,
  // unflushed HLT starts the halt sequence.
  always_comb begin
    next_state_s = ST_RUN;
    case (state_r)
      ST_RUN: begin
        if (id_hlt_s && !stall && !flush) begin
          next_state_s = ST_HALT_PEND;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_HALT_PEND: begin
        if (flush) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_HALTED;
        end
      end
      ST_HALTED: begin
        next_state_s = ST_HALTED;
      end
      default: begin
        next_state_s = ST_RUN;
      end
    endcase
  end

  // Priority mux for the pipeline register contents. Flush loads the fetch
  // PC fields alongside the bubble so the squashed slot still carries a
  // meaningful PC. In HALT_PEND/HALTED only bubbles enter, PC fields hold.
  always_comb begin
    instr_en_s = 1'b1;
    instr_d_s  = NOP_INSTR;
    pc_en_s    = 1'b0;
    valid_d_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (flush) begin
          instr_en_s = 1'b1;
          instr_d_s  = NOP_INSTR;
          pc_en_s    = 1'b1;
          valid_d_s  = 1'b0;
        end else if (stall) begin
          instr_en_s = 1'b0;
          instr_d_s  = if_instr;
          pc_en_s    = 1'b0;
          valid_d_s  = valid_r;
        end else begin
          instr_en_s = 1'b1;
          instr_d_s  = if_instr;
          pc_en_s    = 1'b1;
          valid_d_s  = 1'b1;
        end
      end
      ST_HALT_PEND: begin
        if (flush) begin
          instr_en_s = 1'b1;
          instr_d_s  = NOP_INSTR;
          pc_en_s    = 1'b1;
          valid_d_s  = 1'b0;
        end else begin
          instr_en_s = 1'b1;
          instr_d_s  = NOP_INSTR;
          pc_en_s    = 1'b0;
          valid_d_s  = 1'b0;
        end
      end
      ST_HALTED: begin
        instr_en_s = 1'b1;
        instr_d_s  = NOP_INSTR;
        pc_en_s    = 1'b0;
        valid_d_s  = 1'b0;
      end
      default: begin
        instr_en_s = 1'b1;
        instr_d_s  = NOP_INSTR;
        pc_en_s    = 1'b0;
        valid_d_s  = 1'b0;
      end
    endcase
  end

  // Valid flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_d_s;
    end
  end

  pipe_reg16 u_instr_reg (
    .clk     (clk),
    .rst     (rst),
    .en      (instr_en_s),
    .rst_val (NOP_INSTR),
    .d       (instr_d_s),
    .q       (id_instr)
  );

  pipe_reg16 u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .en      (pc_en_s),
    .rst_val (CPU_PC_RESET),
    .d       (if_pc),
    .q       (id_pc)
  );

  pipe_reg16 u_pc_plus_two_reg (
    .clk     (clk),
    .rst     (rst),
    .en      (pc_en_s),
    .rst_val (CPU_PC_RESET),
    .d       (if_pc_plus_two),
    .q       (id_pc_plus_two)
  );

  assign id_valid   = valid_r;
  assign id_hlt     = id_hlt_s;
  assign halted     = halted_s;
  assign fetch_hold = stall | halted_s | halt_pend_s;

endmodule : if_id_reg
